// File: rtl/delta_weight_gen_pkg.sv
// Shared types and constants for the delta weight/bias generator.
package delta_weight_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POS  = 2'd1,
        ST_NEG  = 2'd2
    } dw_state_e;

    localparam int DW_NWBITS    = 16;
    localparam int DW_NHBITS    = 26;
    localparam int DW_SHIFT     = 13;
    localparam int DW_BIAS_STEP = 2;

    // Symmetric clamp magnitude for an nwbits-wide signed result.
    function automatic longint sat_limit(input int nwbits);
        return (longint'(1) << (nwbits - 1)) - 1;
    endfunction

endpackage

// File: rtl/dw_lane_scale.sv
// One lane: learning-rate shift (floor, or round-half-away when DELTA_WEIGHT_ROUND_EN
// is defined), optional negate, and symmetric saturation.
module dw_lane_scale
    import delta_weight_gen_pkg::*;
#(
    parameter int NWBITS = DW_NWBITS,
    parameter int NHBITS = DW_NHBITS,
    parameter int SHIFT  = DW_SHIFT
) (
    input  logic signed [NHBITS-1:0] x,
    input  logic                     neg,
    output logic signed [NWBITS-1:0] y,
    output logic                     sat
);
    // Two guard bits: one for negating the most negative input, one for sign.
    localparam int W = NHBITS + 2;
    localparam logic signed [W-1:0] LIM = W'(sat_limit(NWBITS));

    logic signed [W-1:0] xe;
    logic signed [W-1:0] s;
    logic signed [W-1:0] v;

    assign xe = {{2{x[NHBITS-1]}}, x};

`ifdef DELTA_WEIGHT_ROUND_EN
    logic [W-1:0] mag;
    logic [W-1:0] mag_r;
    assign mag   = x[NHBITS-1] ? W'(-xe) : W'(xe);
    assign mag_r = (mag + (W'(1) << (SHIFT - 1))) >> SHIFT;
    assign s     = x[NHBITS-1] ? -signed'(mag_r) : signed'(mag_r);
`else
    assign s = xe >>> SHIFT;
`endif

    assign v = neg ? -s : s;

    always_comb begin
        sat = 1'b0;
        y   = NWBITS'(v);
        if (v > LIM) begin
            sat = 1'b1;
            y   = NWBITS'(LIM);
        end else if (v < -LIM) begin
            sat = 1'b1;
            y   = NWBITS'(-LIM);
        end
    end

endmodule

// File: rtl/delta_weight_gen.sv
// Streams NBEATS beats of NCH hidden products into scaled, signed, saturated delta
// weights plus a one-cycle delta bias. Rounding mode selected by DELTA_WEIGHT_ROUND_EN.
module delta_weight_gen
    import delta_weight_gen_pkg::*;
#(
    parameter int NWBITS    = DW_NWBITS,
    parameter int NHBITS    = DW_NHBITS,
    parameter int NCH       = 1,
    parameter int NBEATS    = 256,
    parameter int CNT_BITS  = 8,
    parameter int SHIFT     = DW_SHIFT,
    parameter int BIAS_STEP = DW_BIAS_STEP
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic                    start_pos,
    input  logic                    start_neg,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [NCH*NHBITS-1:0]   hidden_multiply,
    output logic                    out_valid,
    output logic [NCH*NWBITS-1:0]   delta_weight,
    output logic [NWBITS-1:0]       delta_bias,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag
);
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(NBEATS - 1);
    localparam logic [NWBITS-1:0]   BIAS = NWBITS'(BIAS_STEP);

    dw_state_e             state;
    logic [CNT_BITS-1:0]   cnt;
    logic [NCH*NWBITS-1:0] lane_y;
    logic [NCH-1:0]        lane_sat;
    logic                  lane_neg;

    assign lane_neg = (state == ST_NEG);
    assign busy     = (state != ST_IDLE);

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_lane
            dw_lane_scale #(
                .NWBITS (NWBITS),
                .NHBITS (NHBITS),
                .SHIFT  (SHIFT)
            ) u_lane (
                .x   (hidden_multiply[g*NHBITS +: NHBITS]),
                .neg (lane_neg),
                .y   (lane_y[g*NWBITS +: NWBITS]),
                .sat (lane_sat[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            out_valid    <= 1'b0;
            delta_weight <= '0;
            delta_bias   <= '0;
            done         <= 1'b0;
            sat_flag     <= 1'b0;
        end else if (abort && state != ST_IDLE) begin
            // Cancel keeps delta_weight and sat_flag so the aborted update stays inspectable.
            state      <= ST_IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            delta_bias <= '0;
        end else begin
            delta_bias <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_pos) begin
                        state      <= ST_POS;
                        cnt        <= '0;
                        sat_flag   <= 1'b0;
                        delta_bias <= BIAS;
                    end else if (start_neg) begin
                        state      <= ST_NEG;
                        cnt        <= '0;
                        sat_flag   <= 1'b0;
                        delta_bias <= -BIAS;
                    end
                end
                default: begin
                    if (in_valid) begin
                        out_valid    <= 1'b1;
                        delta_weight <= lane_y;
                        sat_flag     <= sat_flag | (|lane_sat);
                        if (cnt == LAST) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delta_weight_gen.sv
// Scoreboard bench: a default instance and a 4-lane/64-beat/SHIFT=8 instance.
module tb_delta_weight_gen;
    localparam int NB0 = 256, NB1 = 64, SH0 = 13, SH1 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rb0, sp0, sn0, ab0, iv0, ov0, busy0, done0, sat0;
    logic [25:0] hm0;
    logic [15:0] dw0, db0;
    logic rb1, sp1, sn1, ab1, iv1, ov1, busy1, done1, sat1;
    logic [103:0] hm1;
    logic [63:0] dw1;
    logic [15:0] db1;

    delta_weight_gen u_dut0 (
        .clk(clk), .reset_b(rb0), .start_pos(sp0), .start_neg(sn0), .abort(ab0),
        .in_valid(iv0), .hidden_multiply(hm0), .out_valid(ov0), .delta_weight(dw0),
        .delta_bias(db0), .busy(busy0), .done(done0), .sat_flag(sat0)
    );

    delta_weight_gen #(.NCH(4), .NBEATS(NB1), .CNT_BITS(6), .SHIFT(SH1)) u_dut1 (
        .clk(clk), .reset_b(rb1), .start_pos(sp1), .start_neg(sn1), .abort(ab1),
        .in_valid(iv1), .hidden_multiply(hm1), .out_valid(ov1), .delta_weight(dw1),
        .delta_bias(db1), .busy(busy1), .done(done1), .sat_flag(sat1)
    );

    typedef struct { logic [3:0][15:0] dw; bit done; longint due; } beat_t;
    typedef struct { longint due; logic [15:0] bias; bit busy; bit sat; } cyc_t;

    beat_t bq0[$], bq1[$];
    cyc_t  cq0[$], cq1[$];
    int n_chk = 0, n_fail = 0;
    longint cyc = 0;
    bit m_busy[2], m_neg[2], m_sat[2];
    int m_cnt[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer arithmetic on the mathematical definition.
    function automatic longint ref_delta(input longint x, input bit neg, input int sh,
                                         output bit sat);
        longint d, m, s, lim;
        d   = longint'(1) << sh;
        lim = 32767;
        m   = (x < 0) ? -x : x;
`ifdef DELTA_WEIGHT_ROUND_EN
        m = (m + d / 2) / d;
        s = (x < 0) ? -m : m;
`else
        s = (x >= 0) ? m / d : -((m + d - 1) / d);
`endif
        if (neg) s = -s;
        sat = (s > lim) || (s < -lim);
        return sat ? ((s > 0) ? lim : -lim) : s;
    endfunction

    function automatic longint rnd();
        logic signed [25:0] r;
        r = 26'($urandom);
        return longint'(r);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs on instance i and record what must come out.
    task automatic step(input int i, input bit sp, input bit sn, input bit ab, input bit iv,
                        input longint x0, input longint x1, input longint x2, input longint x3);
        beat_t b;
        cyc_t c;
        bit ls;
        longint bias = 0;
        longint xs[4];
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        if (i == 0) begin
            sp0 = sp; sn0 = sn; ab0 = ab; iv0 = iv; hm0 = xs[0][25:0];
        end else begin
            sp1 = sp; sn1 = sn; ab1 = ab; iv1 = iv;
            for (int l = 0; l < 4; l++) hm1[l*26 +: 26] = xs[l][25:0];
        end
        if (ab && m_busy[i]) begin
            m_busy[i] = 0;
            m_cnt[i]  = 0;
        end else if (!m_busy[i]) begin
            if (sp || sn) begin
                m_busy[i] = 1; m_neg[i] = !sp; m_cnt[i] = 0; m_sat[i] = 0;
                bias = sp ? 2 : -2;
            end
        end else if (iv) begin
            b.dw = '0;
            for (int l = 0; l < ((i == 0) ? 1 : 4); l++) begin
                b.dw[l] = 16'(ref_delta(xs[l], m_neg[i], (i == 0) ? SH0 : SH1, ls));
                m_sat[i] = m_sat[i] | ls;
            end
            b.done = (m_cnt[i] == ((i == 0) ? NB0 : NB1) - 1);
            b.due  = cyc + 1;
            if (b.done) begin m_busy[i] = 0; m_cnt[i] = 0; end
            else m_cnt[i]++;
            if (i == 0) bq0.push_back(b); else bq1.push_back(b);
        end
        c.due = cyc + 1; c.bias = 16'(bias); c.busy = m_busy[i]; c.sat = m_sat[i];
        if (i == 0) cq0.push_back(c); else cq1.push_back(c);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int i, input int n);
        for (int k = 0; k < n; k++) step(i, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mon(input int i, input logic ov, input logic [63:0] dw, input logic [15:0] db,
                       input logic bz, input logic dn, input logic st);
        cyc_t c;
        beat_t b;
        bit hc = 0, hb = 0;
        if (i == 0) begin
            if (cq0.size() > 0 && cq0[0].due <= cyc) begin c = cq0.pop_front(); hc = 1; end
        end else begin
            if (cq1.size() > 0 && cq1[0].due <= cyc) begin c = cq1.pop_front(); hc = 1; end
        end
        if (hc) begin
            chk("delta_bias", longint'($signed(db)), longint'($signed(c.bias)));
            chk("busy", longint'(bz), longint'(c.busy));
            chk("sat_flag", longint'(st), longint'(c.sat));
        end
        if (ov) begin
            if (i == 0 && bq0.size() > 0) begin b = bq0.pop_front(); hb = 1; end
            if (i == 1 && bq1.size() > 0) begin b = bq1.pop_front(); hb = 1; end
            if (!hb) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_out_valid inst %0d @cyc %0d: got 1 expected 0", i, cyc);
            end else begin
                chk("latency", cyc, b.due);
                for (int l = 0; l < ((i == 0) ? 1 : 4); l++)
                    chk("delta_weight", longint'($signed(dw[l*16 +: 16])),
                        longint'($signed(b.dw[l])));
                chk("done", longint'(dn), longint'(b.done));
            end
        end else begin
            chk("done_without_valid", longint'(dn), 0);
        end
    endtask

    always @(negedge clk) begin
        if (rb0) mon(0, ov0, {48'd0, dw0}, db0, busy0, done0, sat0);
        if (rb1) mon(1, ov1, dw1, db1, busy1, done1, sat1);
    end

    initial begin
        rb0 = 0; rb1 = 0;
        {sp0, sn0, ab0, iv0, sp1, sn1, ab1, iv1} = '0;
        hm0 = '0; hm1 = '0;
        for (int i = 0; i < 2; i++) begin m_busy[i] = 0; m_neg[i] = 0; m_sat[i] = 0; m_cnt[i] = 0; end
        #2;
        chk("reset_out_valid", longint'(ov0), 0);
        chk("reset_delta_weight", longint'(dw0), 0);
        chk("reset_delta_bias", longint'(db0), 0);
        chk("reset_busy", longint'(busy0), 0);
        chk("reset_done_sat", longint'({done1, sat1, ov1}), 0);
        @(posedge clk); #1;
        rb0 = 1; rb1 = 1;

        // Positive update, constant product 65536 -> 8.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NB0; k++) step(0, 0, 0, 0, 1, 65536, 0, 0, 0);
        idle(0, 2);

        // Negative update with rounding edge, a start while busy, and 3-cycle gaps.
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NB0; k++) begin
            longint x = (k == 0) ? -65537 : (k < 10) ? 65536 : rnd();
            step(0, (k == 100), 0, 0, 1, x, 0, 0, 0);
            if (k % 40 == 39) idle(0, 3);
        end
        idle(0, 2);

        // Both starts -> POS, abort at beat 50, aborts in IDLE, then full random NEG.
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 50; k++) step(0, 0, 0, 0, 1, rnd(), 0, 0, 0);
        step(0, 0, 0, 1, 1, rnd(), 0, 0, 0);
        idle(0, 1);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < NB0; k++) begin
            step(0, 0, 0, 0, 1, rnd(), 0, 0, 0);
            if ($urandom_range(0, 4) == 0) idle(0, 1);
        end
        idle(0, 2);

        // Four lanes; back-to-back updates, saturation in both signs.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NB1; k++) step(1, 0, 0, 0, 1, 2048, -2048, 256, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NB1; k++)
            if (k == 0) step(1, 0, 0, 0, 1, 33554431, -33554432, 100, -100);
            else step(1, 0, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NB1; k++) begin
            if (k == 0) step(1, 0, 0, 0, 1, 33554431, -33554432, 0, 255);
            else step(1, 0, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
            if (k % 16 == 15) idle(1, 3);
        end
        idle(1, 2);

        // Reset mid-update clears everything immediately.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++)
            step(1, 0, 0, 0, 1, (k == 5) ? 33554431 : 4096, 8192, -4096, 512);
        #2 rb1 = 0;
        #1;
        chk("midreset_out_valid", longint'(ov1), 0);
        chk("midreset_delta_weight", longint'(dw1), 0);
        chk("midreset_delta_bias", longint'(db1), 0);
        chk("midreset_busy", longint'(busy1), 0);
        chk("midreset_done", longint'(done1), 0);
        chk("midreset_sat_flag", longint'(sat1), 0);
        {sp1, sn1, ab1, iv1} = '0;
        hm1 = '0;
        cq1.delete(); bq1.delete();
        m_busy[1] = 0; m_cnt[1] = 0; m_sat[1] = 0;
        @(posedge clk); #1;
        rb1 = 1;
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NB1; k++) step(1, 0, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
        idle(1, 2);

        @(negedge clk);
        @(negedge clk);
        chk("pending_beats", longint'(bq0.size() + bq1.size()), 0);
        chk("pending_cycles", longint'(cq0.size() + cq1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/delta_weight_gen.md
Name: delta_weight_gen

Overview:
Parametrised successor to the layer-2 delta-weight/delta-bias generators. It streams NBEATS beats of NCH hidden products per training update and emits NCH signed delta weights per beat. Each delta is the product scaled by a 2^-SHIFT learning rate, sign-applied for positive or negative error, and saturated to NWBITS. It also emits a one-cycle delta bias and sits between the hidden-multiply datapath and the weight-update adders.

Parameters:
NWBITS, 16, delta weight/bias width (signed)
NHBITS, 26, hidden product width (signed)
NCH, 1, lanes processed per beat
NBEATS, 256, beats per update (weights per neuron / NCH)
CNT_BITS, 8, beat counter width; must satisfy 2^CNT_BITS >= NBEATS
SHIFT, 13, learning-rate exponent (lr = 2^-SHIFT)
BIAS_STEP, 2, magnitude of delta bias

Ports:
clk  in  1  clock
reset_b  in  1  reset, asynchronous, active-low
start_pos  in  1  begin update, positive error
start_neg  in  1  begin update, negative error
abort  in  1  synchronous cancel
in_valid  in  1  hidden_multiply beat valid
hidden_multiply  in  NCH*NHBITS  packed signed products, lane 0 in LSBs
out_valid  out  1  delta_weight valid
delta_weight  out  NCH*NWBITS  packed signed deltas
delta_bias  out  NWBITS  signed bias delta
busy  out  1  update in progress
done  out  1  one-cycle pulse with last beat's output
sat_flag  out  1  sticky: some lane saturated during current/last update

Behaviour:
- Clock clk; reset reset_b, asynchronous, active-low.
- Reset: state IDLE, counter 0, all outputs 0.
- States: IDLE, POS, NEG. busy = (state != IDLE).
- IDLE: start_pos -> POS; else start_neg -> NEG. If both are asserted, start_pos wins. Starting clears sat_flag and the counter.
- The start cycle drives delta_bias = +BIAS_STEP (POS) or -BIAS_STEP (NEG) on the next cycle for exactly one cycle; otherwise delta_bias = 0.
- Starts while busy are ignored, and delta_bias stays 0.
- In the start cycle, in_valid is ignored. Beats are accepted only in POS/NEG.
- POS/NEG: each in_valid beat gives out_valid=1 and delta_weight on the next cycle (latency 1).
- When in_valid=0, out_valid goes to 0 and delta_weight holds its last value. No stalls toward the upstream.
- Per lane:
  - s = floor(x / 2^SHIFT), an arithmetic right shift.
  - In NEG, s = -s; negate after the shift, at NHBITS+1 bits.
  - Saturate to [-(2^(NWBITS-1)-1), +(2^(NWBITS-1)-1)] (symmetric).
  - Set sat_flag if clamped.
- Counter increments per accepted beat. At beat NBEATS-1: done pulses coincident with that beat's out_valid, then state returns to IDLE and counter to 0. A new start is accepted in the cycle after the last beat.
- abort (highest priority after reset): next cycle state IDLE, counter 0, out_valid 0, done 0, delta_bias 0. sat_flag is retained.
- abort in IDLE has no effect.
- sat_flag holds until the next start.

Optional Feature:
Macro DELTA_WEIGHT_ROUND_EN.
- Defined: round half away from zero before saturation, applied as s = sign(x) * floor((|x| + 2^(SHIFT-1)) / 2^SHIFT); it requires SHIFT >= 1.
- Undefined: plain floor (arithmetic shift) as above.
- Latency is unchanged in both cases.

Decomposition:
- Shared package: state encoding (IDLE/POS/NEG), default widths NWBITS/NHBITS, SHIFT default, BIAS_STEP, and the saturation limit constant function.
- One sub-module dw_lane_scale: combinational shift/round, negate and saturate for one lane. It takes a sign select and outputs the value and a sat bit, and is instantiated NCH times via generate.
- The FSM, counter, registers and bias stay in the top.

Test Plan:
- Defaults (NCH=1): start_pos, then 256 beats of x=65536 -> 256 outputs of 8, done on the 256th output, delta_bias=+2 for one cycle, busy low after.
- start_neg with x=65536 -> -8. With x=-65537: floor gives -9 negated to +9; with DELTA_WEIGHT_ROUND_EN, -8 negated to +8.
- SHIFT=8, x=2^25-1 in POS -> 32767 and sat_flag=1. Same x in NEG -> -32767; x=-2^25 in POS -> -32767.
- start_pos and start_neg both asserted -> POS. A start at beat 100 is ignored and delta_bias stays 0. in_valid gaps of 3 cycles -> out_valid gaps, count unaffected, done still on the 256th beat.
- abort at beat 50 -> IDLE next cycle, no done. A following start_neg runs a full 256 beats.
- NCH=4, NBEATS=64: lanes {65536, -65536, 8192, 0} -> {8, -8, 1, 0}. done after 64 beats. reset_b asserted mid-update -> all outputs 0 immediately.
